// File: rtl/ram_pkg.sv
// ram_pkg
//  Shared types and defaults for the word-RAM initiator.
//  - state_e      : controller phase (IDLE, SETUP, STROBE, HOLD)
//  - DEF_AW/DEF_DW: default address / data widths of the word array
//  - max2         : elaboration-time helper for sizing the phase counter
package ram_pkg;

    localparam int DEF_AW = 4;
    localparam int DEF_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ram_word_ctrl_timer.sv
// ram_word_ctrl_timer
//  Loadable down-counter that measures the length of a controller phase.
//  Loading N-1 makes done assert after N cycles in the phase.
//  Ports:
//   clk      in  clock
//   rst      in  asynchronous active-high reset
//   load     in  load load_val this cycle
//   load_val in  CW  start value (phase length - 1)
//   done     out count has reached zero
module ram_word_ctrl_timer #(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/ram_word_ctrl.sv
// ram_word_ctrl
//  Initiator for a latch-based word RAM array. Takes one read or write at a
//  time from a valid/ready host port and drives the one-hot chip-selects,
//  shared write strobe and shared D bus with setup, strobe width and hold.
//  Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    host handshake (ready only while idle)
//   req_we/addr/wdata      request: 1 = write, word index, write data
//   rsp_valid              one-cycle completion pulse
//   rsp_rdata              last read data (held across writes)
//   ram_cs                 one-hot word selects (2**AW bits)
//   ram_w                  shared write enable
//   ram_d                  shared write data bus
//   ram_q                  shared read data bus
module ram_word_ctrl
    import ram_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_addr,
    input  logic [DW-1:0]     req_wdata,
    output logic              rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic [(1<<AW)-1:0] ram_cs,
    output logic              ram_w,
    output logic [DW-1:0]     ram_d,
    input  logic [DW-1:0]     ram_q
);

    localparam int NW = 1 << AW;
    localparam int CW = $clog2(max2(SETUP_CYC, STROBE_CYC) + 1);
    localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYC - 1);

    state_e            state_reg, state_next;
    logic              we_reg;
    logic [AW-1:0]     addr_reg;
    logic [DW-1:0]     ram_d_reg;
    logic [DW-1:0]     rsp_rdata_reg;
    logic [NW-1:0]     ram_cs_reg, ram_cs_next;
    logic              ram_w_reg, ram_w_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [NW-1:0]     cs_decode;
    logic              accept;
    logic              timer_load;
    logic [CW-1:0]     timer_val;
    logic              timer_done;

    // Ready is withheld while reset is held so nothing is accepted then.
    assign req_ready = (state_reg == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // One-hot decode of the latched address; addr_reg is frozen for the
    // whole operation, so the selected word cannot change mid-strobe.
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_decode
            assign cs_decode[gi] = (addr_reg == AW'(gi));
        end
    endgenerate

    ram_word_ctrl_timer #(
        .CW(CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_comb begin
        state_next     = state_reg;
        timer_load     = 1'b0;
        timer_val      = '0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SETUP;
                    timer_load = 1'b1;
                    timer_val  = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (timer_done) begin
                    state_next = STROBE;
                    timer_load = 1'b1;
                    timer_val  = STROBE_LOAD;
                end
            end
            STROBE: begin
                if (timer_done) begin
                    state_next = HOLD;
                end
            end
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // RAM-side outputs are registered from the next state so they switch
        // cleanly on the phase boundary.
        ram_cs_next    = (state_next == STROBE) ? cs_decode : '0;
        ram_w_next     = (state_next == STROBE) && we_reg;
        rsp_valid_next = (state_next == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            ram_d_reg     <= '0;
            rsp_rdata_reg <= '0;
            ram_cs_reg    <= '0;
            ram_w_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ram_cs_reg    <= ram_cs_next;
            ram_w_reg     <= ram_w_next;
            rsp_valid_reg <= rsp_valid_next;
            if (accept) begin
                we_reg   <= req_we;
                addr_reg <= req_addr;
                if (req_we) begin
                    ram_d_reg <= req_wdata;
                end
            end
            // Capture the Q bus on the last strobe edge, while cs is still high.
            if (state_reg == STROBE && timer_done && !we_reg) begin
                rsp_rdata_reg <= ram_q;
            end
        end
    end

    assign ram_cs    = ram_cs_reg;
    assign ram_w     = ram_w_reg;
    assign ram_d     = ram_d_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule
